// File: rtl/alu_arbiter.sv
//-----------------------------------------------------------------------------
// alu_arbiter
// Two-requester arbiter/sequencer in front of a shared combinational ALU.
// A winner's operands/opcode are registered onto the ALU inputs. The block
// waits LATENCY cycles for the ALU to settle, then captures RESULT/ZERO and
// pulses the winner's DONE strobe for one cycle.
//
// Optional feature macro: ALU_ARB_RR_EN
//   defined   -> round-robin between requesters using the LAST pointer
//   undefined -> fixed priority, requester 0 always wins a conflict
//
// Ports
//   CLK, RESET                 clock, asynchronous active-low reset
//   REQ0/REQ1                  level requests
//   DATA1_x, DATA2_x, SELECT_x operands/opcode of requester x
//   GNT0/GNT1                  one-cycle grant strobe (operands captured)
//   DONE0/DONE1                one-cycle completion strobe
//   RESULT, ZERO               captured ALU outputs, held until next capture
//   BUSY                       high while an operation is in EXEC or DONE
//   ALU_DATA1/2, ALU_SELECT    registered drive to the ALU
//   ALU_RESULT, ALU_ZERO       ALU outputs
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_arbiter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned LATENCY = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             REQ0,
   input  logic             REQ1,
   input  logic [WIDTH-1:0] DATA1_0,
   input  logic [WIDTH-1:0] DATA2_0,
   input  logic [2:0]       SELECT_0,
   input  logic [WIDTH-1:0] DATA1_1,
   input  logic [WIDTH-1:0] DATA2_1,
   input  logic [2:0]       SELECT_1,
   output logic             GNT0,
   output logic             GNT1,
   output logic             DONE0,
   output logic             DONE1,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             BUSY,
   output logic [WIDTH-1:0] ALU_DATA1,
   output logic [WIDTH-1:0] ALU_DATA2,
   output logic [2:0]       ALU_SELECT,
   input  logic [WIDTH-1:0] ALU_RESULT,
   input  logic             ALU_ZERO
);

   localparam int unsigned CNT_W = 4;
   // Keep the wait count inside the legal 1..15 window even if misconfigured.
   localparam int unsigned LAT_C = (LATENCY < 1)  ? 1  :
                                   (LATENCY > 15) ? 15 : LATENCY;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               owner_q;     // 0: requester 0 owns the ALU, 1: requester 1
   logic               gnt0_q, gnt1_q;
   logic               done0_q, done1_q;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q;
   logic               busy_q;
   logic [WIDTH-1:0]   alu_d1_q, alu_d2_q;
   logic [2:0]         alu_sel_q;
   logic               win_c;

`ifdef ALU_ARB_RR_EN
   logic               last_q;      // most recently served requester
`endif

   // Winner selection among currently asserted requests.
   always_comb begin
      win_c = 1'b0;
      if (REQ0 && REQ1) begin
`ifdef ALU_ARB_RR_EN
         win_c = ~last_q;
`else
         win_c = 1'b0;
`endif
      end else if (REQ1) begin
         win_c = 1'b1;
      end
   end

   // Sequencer: grant, settle wait, capture, completion strobe.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         owner_q   <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         busy_q    <= 1'b0;
         alu_d1_q  <= '0;
         alu_d2_q  <= '0;
         alu_sel_q <= '0;
`ifdef ALU_ARB_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         // Strobes are single-cycle unless set again below.
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               if (REQ0 || REQ1) begin
                  owner_q   <= win_c;
                  alu_d1_q  <= win_c ? DATA1_1  : DATA1_0;
                  alu_d2_q  <= win_c ? DATA2_1  : DATA2_0;
                  alu_sel_q <= win_c ? SELECT_1 : SELECT_0;
                  gnt0_q    <= ~win_c;
                  gnt1_q    <= win_c;
                  busy_q    <= 1'b1;
                  cnt_q     <= CNT_W'(LAT_C - 1);
                  state_q   <= ST_EXEC;
               end
            end

            ST_EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  result_q <= ALU_RESULT;
                  zero_q   <= ALU_ZERO;
                  done0_q  <= ~owner_q;
                  done1_q  <= owner_q;
`ifdef ALU_ARB_RR_EN
                  last_q   <= owner_q;
`endif
                  state_q  <= ST_DONE;
               end
            end

            ST_DONE: begin
               // Requests seen here are deliberately ignored; they are
               // re-evaluated on the next IDLE edge.
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign GNT0       = gnt0_q;
   assign GNT1       = gnt1_q;
   assign DONE0      = done0_q;
   assign DONE1      = done1_q;
   assign RESULT     = result_q;
   assign ZERO       = zero_q;
   assign BUSY       = busy_q;
   assign ALU_DATA1  = alu_d1_q;
   assign ALU_DATA2  = alu_d2_q;
   assign ALU_SELECT = alu_sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
//-----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter (WIDTH=8, LATENCY=2) with a behavioural ALU:
// 000 forward DATA2, 001 add, 010 and, 011 or; ZERO from the adder output.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       REQ0, REQ1;
   logic [7:0] DATA1_0, DATA2_0, DATA1_1, DATA2_1;
   logic [2:0] SELECT_0, SELECT_1;
   logic       GNT0, GNT1, DONE0, DONE1, ZERO, BUSY;
   logic [7:0] RESULT, ALU_DATA1, ALU_DATA2, ALU_RESULT;
   logic [2:0] ALU_SELECT;
   logic       ALU_ZERO;
   logic [7:0] alu_sum;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   alu_arbiter #(.WIDTH(8), .LATENCY(2)) dut (
      .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1),
      .DATA1_0(DATA1_0), .DATA2_0(DATA2_0), .SELECT_0(SELECT_0),
      .DATA1_1(DATA1_1), .DATA2_1(DATA2_1), .SELECT_1(SELECT_1),
      .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
      .RESULT(RESULT), .ZERO(ZERO), .BUSY(BUSY),
      .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
      .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO)
   );

   // Behavioural ALU model.
   always_comb begin
      alu_sum = ALU_DATA1 + ALU_DATA2;
      case (ALU_SELECT)
         3'b000:  ALU_RESULT = ALU_DATA2;
         3'b001:  ALU_RESULT = alu_sum;
         3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
         3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
         default: ALU_RESULT = 8'h00;
      endcase
      ALU_ZERO = (alu_sum == 8'h00);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock; sample and drive 1 time unit after the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({GNT0, GNT1, DONE0, DONE1, RESULT, ZERO, BUSY,
                  ALU_DATA1, ALU_DATA2, ALU_SELECT});
   endfunction

   initial begin
      logic exp_w;
      RESET = 1'b0;
      REQ0 = 1'b0; REQ1 = 1'b0;
      DATA1_0 = '0; DATA2_0 = '0; SELECT_0 = '0;
      DATA1_1 = '0; DATA2_1 = '0; SELECT_1 = '0;
      step(); step();
      check("reset_outputs", all_outs(), 64'h0);
      RESET = 1'b1;

      // Single request: 5 + 3.
      REQ0 = 1'b1; DATA1_0 = 8'h05; DATA2_0 = 8'h03; SELECT_0 = 3'b001;
      step();
      check("t1_gnt0",  GNT0, 1'b1);
      check("t1_gnt1",  GNT1, 1'b0);
      check("t1_busy0", BUSY, 1'b1);
      check("t1_alu",   {ALU_DATA1, ALU_DATA2, 5'(ALU_SELECT)}, {8'h05, 8'h03, 5'd1});
      REQ0 = 1'b0;
      step();
      check("t1_gnt0_off", GNT0, 1'b0);
      check("t1_busy1",    BUSY, 1'b1);
      check("t1_nodone",   DONE0, 1'b0);
      step();
      check("t1_done0", DONE0, 1'b1);
      check("t1_done1", DONE1, 1'b0);
      check("t1_result", RESULT, 8'h08);
      check("t1_zero",   ZERO, 1'b0);
      check("t1_busy2",  BUSY, 1'b1);
      step();
      check("t1_done_off", DONE0, 1'b0);
      check("t1_busy_off", BUSY, 1'b0);
      check("t1_hold", {RESULT, ALU_DATA1}, {8'h08, 8'h05});

      // Requester 1 producing a zero result: FF + 01.
      REQ1 = 1'b1; DATA1_1 = 8'hFF; DATA2_1 = 8'h01; SELECT_1 = 3'b001;
      step();
      check("t2_gnt", {GNT0, GNT1}, 2'b01);
      REQ1 = 1'b0;
      step();
      check("t2_mid", {GNT0, GNT1, DONE0, DONE1}, 4'b0000);
      step();
      check("t2_done", {DONE0, DONE1}, 2'b01);
      check("t2_result", RESULT, 8'h00);
      check("t2_zero",   ZERO, 1'b1);
      step();
      check("t2_idle", {DONE1, BUSY}, 2'b00);

      // Operands are frozen at the grant edge (forward DATA2 = 03).
      REQ0 = 1'b1; DATA1_0 = 8'h03; DATA2_0 = 8'h03; SELECT_0 = 3'b000;
      step();
      check("t4_gnt0", GNT0, 1'b1);
      DATA2_0 = 8'h7F; REQ0 = 1'b0;
      step();
      check("t4_alu_d2", ALU_DATA2, 8'h03);
      step();
      check("t4_done0",  DONE0, 1'b1);
      check("t4_result", RESULT, 8'h03);
      check("t4_zero",   ZERO, 1'b0);
      step();

      // Reset in the middle of EXEC drops the operation.
      REQ0 = 1'b1; DATA1_0 = 8'h11; DATA2_0 = 8'h22; SELECT_0 = 3'b001;
      step();
      check("t5_gnt0", GNT0, 1'b1);
      REQ0 = 1'b0;
      step();
      check("t5_exec_busy", BUSY, 1'b1);
      RESET = 1'b0;
      #1;
      check("t5_async_reset", all_outs(), 64'h0);
      // Both requesters hold REQ from reset for the conflict test.
      REQ0 = 1'b1; DATA1_0 = 8'h0C; DATA2_0 = 8'h0A; SELECT_0 = 3'b010;
      REQ1 = 1'b1; DATA1_1 = 8'h0C; DATA2_1 = 8'h0A; SELECT_1 = 3'b011;
      step();
      check("t5_no_done", all_outs(), 64'h0);
      RESET = 1'b1;

      // Conflict: first grant on the first edge after reset release.
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
         exp_w = 1'(i % 2);
`else
         exp_w = 1'b0;
`endif
         step();
         check("t3_gnt", {GNT0, GNT1}, exp_w ? 2'b01 : 2'b10);
         step();
         step();
         check("t3_done", {DONE0, DONE1}, exp_w ? 2'b01 : 2'b10);
         check("t3_result", RESULT, exp_w ? 8'h0E : 8'h08);
         step();
         check("t3_idle", {GNT0, GNT1, BUSY}, 3'b000);
      end

      REQ0 = 1'b0; REQ1 = 1'b0;
      step(); step();
      check("end_idle", BUSY, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
